// File: rtl/minbd_pkg.sv
// Shared MinBD router types and constants.
// Latency: none (declarations only).
// Backpressure: none.
`ifndef WIDTH_PKTSZ
`define WIDTH_PKTSZ 3
`endif

package minbd_pkg;

    // Default network sizing for blocks that are not overridden per instance.
    localparam int WIDTH_NODE  = 4;
    localparam int WIDTH_PKTID = 4;

    // x^8+x^6+x^5+x^4+1 in Fibonacci form: feedback = l[7]^l[5]^l[4]^l[3].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Per-port priority tag handed to the permutation arbiters.
    typedef struct packed {
        logic vld;
        logic gold;
        logic silver;
    } flit_tag_t;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, advances every cycle from a nonzero seed.
// Latency: q is the register value; the next value appears after each edge.
// Backpressure: none, free running.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] q
);
    import minbd_pkg::*;

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/golden_silver_tagger.sv
// Tags incoming flits as gold (current golden packet) or silver (one random pick).
// Latency: 1 cycle from inputs to all tag and data outputs.
// Backpressure: none; a deflection router never stalls.
module golden_silver_tagger #(
    parameter int         NUM_NODE    = 16,
    parameter int         WIDTH_PKTID = 4,
    parameter int         EPOCH_LEN   = 64,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    localparam int        WIDTH_NODE  = $clog2(NUM_NODE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                vld_in,
    input  logic [4*WIDTH_NODE-1:0]   src_in,
    input  logic [4*WIDTH_PKTID-1:0]  pkt_in,
    input  logic [4*`WIDTH_PKTSZ-1:0] flit_id_in,
    output logic [3:0]                vld_vec,
    output logic [3:0]                gold_vec,
    output logic [3:0]                silver_vec,
    output logic [4*`WIDTH_PKTSZ-1:0] flit_id_vec,
    output logic [1:0]                rand_num,
    output logic [WIDTH_NODE-1:0]     golden_node,
    output logic [WIDTH_PKTID-1:0]    golden_pkt
);
    import minbd_pkg::*;

    localparam int                     WIDTH_EPOCH = $clog2(EPOCH_LEN);
    localparam logic [WIDTH_EPOCH-1:0] EP_LAST     = WIDTH_EPOCH'(EPOCH_LEN - 1);
    localparam logic [WIDTH_NODE-1:0]  NODE_LAST   = WIDTH_NODE'(NUM_NODE - 1);
    localparam int                     PS          = `WIDTH_PKTSZ;

    logic [WIDTH_EPOCH-1:0]  ep_cnt;
    logic [7:0]              lfsr;
    flit_tag_t [3:0]         tag_d;
    logic [3:0]              cand;
    logic [1:0]              start;
    logic [1:0]              idx;
    logic                    found;
    logic [4*PS-1:0]         flit_id_d;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign start = lfsr[1:0];

    // Golden epoch: packet ID steps every EPOCH_LEN cycles, node steps when the packet ID wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ep_cnt      <= '0;
            golden_pkt  <= '0;
            golden_node <= '0;
        end else if (ep_cnt == EP_LAST) begin
            ep_cnt     <= '0;
            golden_pkt <= golden_pkt + 1'b1;
            if (golden_pkt == '1) begin
                golden_node <= (golden_node == NODE_LAST) ? '0 : golden_node + 1'b1;
            end
        end else begin
            ep_cnt <= ep_cnt + 1'b1;
        end
    end

    // Gold match against the pre-update golden pair, then a rotating scan for one silver.
    always_comb begin
        tag_d     = '0;
        cand      = '0;
        flit_id_d = '0;
        idx       = '0;
        found     = 1'b0;
        for (int p = 0; p < 4; p++) begin
            tag_d[p].vld  = vld_in[p];
            tag_d[p].gold = vld_in[p]
                          && (src_in[p*WIDTH_NODE +: WIDTH_NODE] == golden_node)
                          && (pkt_in[p*WIDTH_PKTID +: WIDTH_PKTID] == golden_pkt);
            cand[p]       = vld_in[p] && !tag_d[p].gold;
            if (vld_in[p]) begin
                flit_id_d[p*PS +: PS] = flit_id_in[p*PS +: PS];
            end
        end
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && cand[idx]) begin
                tag_d[idx].silver = 1'b1;
                found             = 1'b1;
            end
        end
    end

    // Output stage: tags, pass-through flit IDs and the tie-break bits share one register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_vec     <= '0;
            gold_vec    <= '0;
            silver_vec  <= '0;
            flit_id_vec <= '0;
            rand_num    <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                vld_vec[p]    <= tag_d[p].vld;
                gold_vec[p]   <= tag_d[p].gold;
                silver_vec[p] <= tag_d[p].silver;
            end
            flit_id_vec <= flit_id_d;
            rand_num    <= lfsr[3:2];
        end
    end

endmodule
